// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: bridges a 256-bit single-line cache memory port to a 64-bit, 4-beat burst memory.
// One transaction at a time; read lines are kept in a separate register so write-backs never disturb them.
module cacheline_burst_adapter #(
   parameter  int LINE_WIDTH  = 256,
   parameter  int BURST_WIDTH = 64,
   localparam int BEATS       = LINE_WIDTH / BURST_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            pmem_address,
   input  logic                   pmem_read,
   input  logic                   pmem_write,
   input  logic [LINE_WIDTH-1:0]  pmem_wdata,
   output logic [LINE_WIDTH-1:0]  pmem_rdata,
   output logic                   pmem_resp,
   output logic [31:0]            burst_address,
   output logic                   burst_read,
   output logic                   burst_write,
   output logic [BURST_WIDTH-1:0] burst_wdata,
   input  logic [BURST_WIDTH-1:0] burst_rdata,
   input  logic                   burst_resp
);
   localparam int CW = $clog2(BEATS);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t                             r_state, w_next;
   logic [CW-1:0]                      r_cnt;
   logic [BEATS-1:0][BURST_WIDTH-1:0]  r_line, w_line;
   logic [LINE_WIDTH-1:0]              r_rdata;
   logic [31:0]                        r_addr;
   logic                               w_last, w_beat, w_accept;
   assign w_last   = r_cnt == CW'(BEATS - 1);
   assign w_beat   = burst_resp && (r_state == READ || r_state == WRITE);
   assign w_accept = r_state == IDLE && (pmem_read || pmem_write);
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:        w_next = pmem_write ? WRITE : pmem_read ? READ : IDLE;
         READ, WRITE: w_next = (burst_resp && w_last) ? DONE : r_state;
         DONE:        w_next = IDLE;
         default:     w_next = IDLE;
      endcase
   end
   always_comb begin
      w_line        = r_line;
      w_line[r_cnt] = burst_rdata;
   end
   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_line  <= '0;
         r_rdata <= '0;
         r_addr  <= '0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_addr <= pmem_address & ~32'h1F;
         if (pmem_write) r_line <= pmem_wdata;
      end else if (w_beat) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_state == READ) begin
            r_line <= w_line;
            // publish the finished line together with its last beat
            if (w_last) r_rdata <= w_line;
         end
      end
   end
   assign pmem_resp     = r_state == DONE;
   assign pmem_rdata    = r_rdata;
   assign burst_address = r_addr;
   assign burst_read    = r_state == READ;
   assign burst_write   = r_state == WRITE;
   assign burst_wdata   = burst_write ? r_line[r_cnt] : '0;
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter: table vectors, hand-written reset/stray sequences and random transactions
// checked against a line-level model of the adapter.
module tb_cacheline_burst_adapter;
   logic         clk = 1'b0, rst = 1'b0;
   logic [31:0]  pmem_address = '0;
   logic         pmem_read = 1'b0, pmem_write = 1'b0;
   logic [255:0] pmem_wdata = '0, pmem_rdata;
   logic         pmem_resp;
   logic [31:0]  burst_address;
   logic         burst_read, burst_write;
   logic [63:0]  burst_wdata, burst_rdata = '0;
   logic         burst_resp = 1'b0;

   always #5 clk = ~clk;

   cacheline_burst_adapter dut (
      .clk(clk), .rst(rst),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
      .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
   );

   typedef struct {
      logic            rd;
      logic            wr;
      logic [31:0]     addr;
      logic [255:0]    line;
      logic [3:0][1:0] gap;
      logic            exp_wr;
      logic [31:0]     exp_addr;
   } vec_t;

   int           n_vec = 0, n_bad = 0;
   logic [255:0] last_rd = '0;
   vec_t         vecs [5];
   vec_t         v;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered and left #1 after an edge with the DUT in IDLE.
   task automatic run_txn(input vec_t t);
      logic [255:0] exp_rd;
      logic [63:0]  slice;
      pmem_address = t.addr;
      pmem_wdata   = t.line;
      pmem_read    = t.rd;
      pmem_write   = t.wr;
      chk("req_cycle_idle", {burst_read, burst_write, pmem_resp}, 3'b000);
      step();
      chk("burst_address", burst_address, t.exp_addr);
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < int'(t.gap[k]); g++) begin
            chk("gap_flags", {burst_read, burst_write, pmem_resp}, {!t.exp_wr, t.exp_wr, 1'b0});
            step();
         end
         slice       = t.line[k*64 +: 64];
         burst_resp  = 1'b1;
         burst_rdata = t.exp_wr ? ~slice : slice;
         chk("beat_flags", {burst_read, burst_write, pmem_resp}, {!t.exp_wr, t.exp_wr, 1'b0});
         if (t.exp_wr) chk("wdata_beat", burst_wdata, slice);
         step();
         burst_resp  = 1'b0;
         burst_rdata = {$urandom(), $urandom()};
      end
      exp_rd = t.exp_wr ? last_rd : t.line;
      if (!t.exp_wr) last_rd = t.line;
      chk("done_flags", {burst_read, burst_write, pmem_resp}, 3'b001);
      chk("done_rdata", pmem_rdata, exp_rd);
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      step();
      chk("idle_after_done", {burst_read, burst_write, pmem_resp}, 3'b000);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                  {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}},
                  8'h00, 1'b0, 32'h0000_1220};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_ABCD,
                  {64'hD3D3_0303_3333_D3D3, 64'hD2D2_0202_2222_D2D2,
                   64'hD1D1_0101_1111_D1D1, 64'hD0D0_0000_0000_D0D0},
                  {2'd3, 2'd1, 2'd2, 2'd0}, 1'b1, 32'h0000_ABC0};
      vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF,
                  {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                   64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
                  {2'd0, 2'd1, 2'd0, 2'd1}, 1'b1, 32'hFFFF_FFE0};
      vecs[3] = '{1'b0, 1'b1, 32'h8000_0040,
                  {4{64'hBAD0_BAD0_BAD0_BAD0}}, 8'h00, 1'b1, 32'h8000_0040};
      vecs[4] = '{1'b1, 1'b0, 32'h1000_007F,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
                  {2'd2, 2'd3, 2'd0, 2'd1}, 1'b0, 32'h1000_0060};

      step();
      step();
      chk("reset_flags", {burst_read, burst_write, pmem_resp}, 3'b000);
      chk("reset_rdata", pmem_rdata, '0);
      chk("reset_address", burst_address, '0);
      chk("reset_wdata", burst_wdata, '0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 5; i++) run_txn(vecs[i]);

      // reset abandons a read after two beats
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_2468;
      step();
      for (int k = 0; k < 2; k++) begin
         burst_resp  = 1'b1;
         burst_rdata = {2{$urandom()}};
         step();
      end
      burst_resp = 1'b0;
      pmem_read  = 1'b0;
      rst        = 1'b0;
      step();
      last_rd = '0;
      chk("midreset_flags", {burst_read, burst_write, pmem_resp}, 3'b000);
      chk("midreset_rdata", pmem_rdata, '0);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("midreset_no_resp", {burst_read, burst_write, pmem_resp}, 3'b000);
      end
      run_txn(vecs[4]);

      // stray responses in IDLE are ignored
      for (int c = 0; c < 3; c++) begin
         burst_resp  = 1'b1;
         burst_rdata = {$urandom(), $urandom()};
         step();
         chk("stray_flags", {burst_read, burst_write, pmem_resp}, 3'b000);
         chk("stray_rdata", pmem_rdata, last_rd);
      end
      burst_resp = 1'b0;
      run_txn(vecs[0]);

      for (int i = 0; i < 40; i++) begin
         v.wr = 1'($urandom_range(0, 1));
         v.rd = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
         v.addr = $urandom();
         for (int j = 0; j < 8; j++) v.line[j*32 +: 32] = $urandom();
         for (int j = 0; j < 4; j++) v.gap[j] = 2'($urandom_range(0, 3));
         v.exp_wr   = v.wr;
         v.exp_addr = v.addr - (v.addr % 32);
         run_txn(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
- Responder for the cache's 256-bit physical-memory port (pmem_* signals, one full cache line per transaction).
- Initiator toward a 64-bit burst memory: splits each write-back line into 4 beats and assembles each 4-beat read burst into one line.
- Sits between the cache's physical-memory port and the memory/arbiter.
- Single request outstanding at a time.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits.
- BEATS, LINE_WIDTH/BURST_WIDTH (4), beats per line. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset; asserted when rst=0, sampled on the clk rising edge.
- pmem_address  input  32  line address from the cache.
- pmem_read  input  1  line read request; held high until pmem_resp.
- pmem_write  input  1  line write request; held high until pmem_resp.
- pmem_wdata  input  256  line to write; stable while pmem_write is high.
- pmem_rdata  output  256  assembled read line.
- pmem_resp  output  1  one-cycle completion pulse.
- burst_address  output  32  latched line address with bits [4:0] forced to 0.
- burst_read  output  1  burst read request.
- burst_write  output  1  burst write request.
- burst_wdata  output  64  current write beat.
- burst_rdata  input  64  read beat; valid when burst_resp is high.
- burst_resp  input  1  one beat transferred this cycle.

Behaviour:
- Reset (rst=0 at an edge):
  - state goes to IDLE; beat counter goes to 0.
  - pmem_resp, burst_read and burst_write go to 0.
  - pmem_rdata, burst_address and burst_wdata go to 0.
  - Reset overrides any in-flight transfer and abandons it; no pmem_resp is produced for it.
- Beat order: beat k occupies line bits [64k+63:64k], k=0..3, ascending. Beat counter is 2 bits.
- IDLE state:
  - On pmem_write=1: latch pmem_wdata into the line buffer and pmem_address&~32'h1F into burst_address; counter=0; go to WRITE.
  - Else on pmem_read=1: latch the address the same way; counter=0; go to READ.
  - If pmem_read and pmem_write are both 1, the write wins and the read is not serviced.
  - burst_read and burst_write are registered outputs; each rises the cycle after acceptance.
- READ state:
  - burst_read=1.
  - Each cycle with burst_resp=1: write burst_rdata into line buffer slot [counter], then counter+1.
  - Beats may be non-contiguous; cycles with burst_resp=0 hold all state.
  - On the beat with counter==3: drop burst_read at the next edge and go to DONE.
- WRITE state:
  - burst_write=1; burst_wdata is a combinational mux of line buffer slot [counter].
  - Each burst_resp=1 cycle consumes the current beat and advances the counter.
  - Counter==3 with burst_resp=1 ends the burst: burst_write drops and the state goes to DONE.
- DONE state (exactly 1 cycle):
  - pmem_resp=1; pmem_rdata = line buffer (holds the assembled line for reads).
  - Pending pmem_read/pmem_write are ignored this cycle, since the cache drops its request after seeing pmem_resp.
  - Next state: IDLE.
- pmem_rdata holds its value until the next read burst completes. Write transactions do not disturb the read contents visible at pmem_resp.
- burst_resp while in IDLE or DONE is ignored.
- Minimum latency from accept to pmem_resp: 6 cycles (1 request cycle, 4 beats, DONE).
- Back-to-back transactions: a new request is accepted at the earliest in the IDLE cycle following DONE.
- Counter wrap from 3 to 0 occurs only at the burst end; no partial-line transfers exist.

Test Plan:
- Read, contiguous beats: pmem_read=1, pmem_address=0x0000_1234. Response:
  - burst_address=0x0000_1220, burst_read high from the next cycle.
  - Drive burst_resp 4 cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Expect one pmem_resp pulse and pmem_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
  - Expect burst_read low on the pmem_resp cycle.
- Write, non-contiguous beats: pmem_write=1, pmem_wdata={D3,D2,D1,D0}. Insert burst_resp gaps of 0, 2, 1 and 3 cycles.
  - Expect burst_wdata to show D0, D1, D2, D3 at each burst_resp.
  - Expect burst_write low after the 4th beat and a single pmem_resp.
- Simultaneous request: pmem_read=1 and pmem_write=1 in IDLE.
  - Expect burst_write=1 and burst_read=0 for the whole transaction.
- Back-to-back write then read (the cache's dirty-evict sequence):
  - Expect two distinct pmem_resp pulses separated by at least 1 IDLE cycle.
  - Expect the read line to be correct and unaffected by the written line.
- Reset mid-read: drive rst=0 after 2 beats.
  - Expect burst_read=0, pmem_rdata=0 and no pmem_resp at the next edge.
  - A subsequent full read returns the correct line, with the counter restarted at beat 0.
- Stray response: burst_resp=1 pulses in IDLE with no request.
  - Expect no state change, no pmem_resp, and pmem_rdata unchanged.
